// File: rtl/cl.sv
// Camera Link Full-configuration receiver front end.
// Registers the pins once, qualifies pixel beats by frame and line valid,
// marks start of frame and start of line, and measures line and frame size.
// Sticky flags report X/Y/Z line-valid skew and lines of unequal length.
module cl (
   input  logic        cl_x_pclk,
   input  logic        reset,
   input  logic        cl_fval,
   input  logic        cl_x_lval,
   input  logic        cl_y_lval,
   input  logic        cl_z_lval,
   input  logic [7:0]  cl_port_a,
   input  logic [7:0]  cl_port_b,
   input  logic [7:0]  cl_port_c,
   input  logic [7:0]  cl_port_d,
   input  logic [7:0]  cl_port_e,
   input  logic [7:0]  cl_port_f,
   input  logic [7:0]  cl_port_g,
   input  logic [7:0]  cl_port_h,
   input  logic [7:0]  cl_port_i,
   input  logic [7:0]  cl_port_j,
   input  logic        err_clr,
   output logic [79:0] pix_data,
   output logic        pix_valid,
   output logic        pix_sof,
   output logic        pix_sol,
   output logic [15:0] line_beats,
   output logic [15:0] frame_lines,
   output logic [31:0] frame_cnt,
   output logic        err_lval,
   output logic        err_len,
   output logic [7:0]  GPIO_LED
);

   logic        fval_s;
   logic        lval_s;
   logic        y_lval_s;
   logic        z_lval_s;
   logic [79:0] data_s;
   logic        s0_valid;

   logic        fval_d;
   logic        idle_seen;
   logic        in_frame;
   logic        sof_pending;
   logic        active_d;
   logic [15:0] beat_cnt;
   logic [15:0] line_cnt;
   logic [15:0] first_len;

   logic        frame_start;
   logic        in_frame_now;
   logic        active;
   logic        line_start;
   logic        line_end;
   logic        frame_end;
   logic        sof_now;
   logic [15:0] lines_done;
   logic        err_lval_set;
   logic        err_len_set;

   // Input stage s0: every pin is registered once before any decision uses it.
   always_ff @(posedge cl_x_pclk or negedge reset) begin
      if (!reset) begin
         fval_s   <= 1'b0;
         lval_s   <= 1'b0;
         y_lval_s <= 1'b0;
         z_lval_s <= 1'b0;
         data_s   <= '0;
         s0_valid <= 1'b0;
      end else begin
         fval_s   <= cl_fval;
         lval_s   <= cl_x_lval;
         y_lval_s <= cl_y_lval;
         z_lval_s <= cl_z_lval;
         data_s   <= {cl_port_j, cl_port_i, cl_port_h, cl_port_g, cl_port_f,
                      cl_port_e, cl_port_d, cl_port_c, cl_port_b, cl_port_a};
         s0_valid <= 1'b1;
      end
   end

   // A frame only opens on an fval rise seen after fval was low, so a frame
   // already running when reset lifts is skipped entirely.
   always_comb begin
      frame_start  = fval_s & ~fval_d & idle_seen;
      in_frame_now = frame_start | (in_frame & fval_s);
      active       = in_frame_now & lval_s;
      line_start   = active & ~active_d;
      line_end     = active_d & ~active;
      frame_end    = in_frame & ~fval_s;
      sof_now      = active & (frame_start | sof_pending);
      lines_done   = line_cnt;
      if (line_end && line_cnt != 16'hFFFF) begin
         lines_done = line_cnt + 16'd1;
      end
      err_lval_set = fval_s & ((y_lval_s != lval_s) | (z_lval_s != lval_s));
      err_len_set  = line_end & (line_cnt != 16'd0) & (beat_cnt != first_len);
   end

   // Frame/line tracking state and the registered pixel output stage.
   always_ff @(posedge cl_x_pclk or negedge reset) begin
      if (!reset) begin
         fval_d      <= 1'b0;
         idle_seen   <= 1'b0;
         in_frame    <= 1'b0;
         sof_pending <= 1'b0;
         active_d    <= 1'b0;
         pix_data    <= '0;
         pix_valid   <= 1'b0;
         pix_sof     <= 1'b0;
         pix_sol     <= 1'b0;
      end else begin
         fval_d      <= fval_s;
         idle_seen   <= idle_seen | (s0_valid & ~fval_s);
         in_frame    <= in_frame_now;
         sof_pending <= (frame_start | sof_pending) & in_frame_now & ~active;
         active_d    <= active;
         pix_valid   <= active;
         pix_sof     <= sof_now;
         pix_sol     <= line_start;
         if (active) begin
            pix_data <= data_s;
         end
      end
   end

   // Beat, line and frame counters; a line cut by fval falling is closed
   // before the frame so it lands in frame_lines.
   always_ff @(posedge cl_x_pclk or negedge reset) begin
      if (!reset) begin
         beat_cnt    <= '0;
         line_cnt    <= '0;
         first_len   <= '0;
         line_beats  <= '0;
         frame_lines <= '0;
         frame_cnt   <= '0;
      end else begin
         if (line_start) begin
            beat_cnt <= 16'd1;
         end else if (active && beat_cnt != 16'hFFFF) begin
            beat_cnt <= beat_cnt + 16'd1;
         end
         if (line_end) begin
            line_beats <= beat_cnt;
            if (line_cnt == 16'd0) begin
               first_len <= beat_cnt;
            end
         end
         if (frame_end) begin
            frame_lines <= lines_done;
            frame_cnt   <= frame_cnt + 32'd1;
            line_cnt    <= '0;
         end else begin
            line_cnt <= lines_done;
         end
      end
   end

   // Sticky error flags; a new error in the clearing cycle keeps the flag set.
   always_ff @(posedge cl_x_pclk or negedge reset) begin
      if (!reset) begin
         err_lval <= 1'b0;
         err_len  <= 1'b0;
      end else begin
         err_lval <= err_lval_set | (err_lval & ~err_clr);
         err_len  <= err_len_set | (err_len & ~err_clr);
      end
   end

   assign GPIO_LED = {fval_s, lval_s, err_lval | err_len, frame_cnt[4:0]};

endmodule

// File: tb/tb_cl.sv
// Self-checking bench for cl: drives frames on the pixel bus, predicts each
// output beat into a scoreboard queue and compares as the DUT emits beats.
module tb_cl;

   typedef struct {
      int unsigned cyc;
      logic [79:0] data;
      logic        sof;
      logic        sol;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fval = 1'b0;
   logic        xLval = 1'b0;
   logic        yLval = 1'b0;
   logic        zLval = 1'b0;
   logic [79:0] pixBus = '0;
   logic        errClr = 1'b0;

   logic [79:0] pix_data;
   logic        pix_valid;
   logic        pix_sof;
   logic        pix_sol;
   logic [15:0] line_beats;
   logic [15:0] frame_lines;
   logic [31:0] frame_cnt;
   logic        err_lval;
   logic        err_len;
   logic [7:0]  GPIO_LED;

   int unsigned cyc = 0;
   int          checkCount = 0;
   int          errorCount = 0;
   beat_t       sb[$];
   beat_t       expBeat;
   logic [79:0] lastData = '0;

   cl dut (
      .cl_x_pclk  (clk),
      .reset      (reset),
      .cl_fval    (fval),
      .cl_x_lval  (xLval),
      .cl_y_lval  (yLval),
      .cl_z_lval  (zLval),
      .cl_port_a  (pixBus[7:0]),
      .cl_port_b  (pixBus[15:8]),
      .cl_port_c  (pixBus[23:16]),
      .cl_port_d  (pixBus[31:24]),
      .cl_port_e  (pixBus[39:32]),
      .cl_port_f  (pixBus[47:40]),
      .cl_port_g  (pixBus[55:48]),
      .cl_port_h  (pixBus[63:56]),
      .cl_port_i  (pixBus[71:64]),
      .cl_port_j  (pixBus[79:72]),
      .err_clr    (errClr),
      .pix_data   (pix_data),
      .pix_valid  (pix_valid),
      .pix_sof    (pix_sof),
      .pix_sol    (pix_sol),
      .line_beats (line_beats),
      .frame_lines(frame_lines),
      .frame_cnt  (frame_cnt),
      .err_lval   (err_lval),
      .err_len    (err_len),
      .GPIO_LED   (GPIO_LED)
   );

   // Free-running pixel clock and a cycle counter for latency checks.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [79:0] actual, input logic [79:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, wanted %0h", tag, actual, expected);
      end
   endtask

   // Drive one clock of pins; a beat the DUT should emit is predicted two
   // clocks later (one input register, one output register).
   task automatic applyStimulus(input logic f, input logic l, input logic y, input logic z,
                                input logic [79:0] d, input logic expValid,
                                input logic expSof, input logic expSol);
      beat_t b;
      @(negedge clk);
      fval   = f;
      xLval  = l;
      yLval  = y;
      zLval  = z;
      pixBus = d;
      if (expValid) begin
         b.cyc  = cyc + 2;
         b.data = d;
         b.sof  = expSof;
         b.sol  = expSol;
         sb.push_back(b);
         lastData = d;
      end
   endtask

   function automatic logic [79:0] randBeat(input int idx);
      logic [79:0] d;
      d = {16'($urandom), 32'($urandom), 32'($urandom)};
      d[7:0] = 8'(idx);
      return d;
   endfunction

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   // Full frame: first line firstBeats long, the rest restBeats long.
   task automatic sendFrame(input int nLines, input int firstBeats, input int restBeats);
      int nb;
      idle(2);
      repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int ln = 0; ln < nLines; ln++) begin
         nb = (ln == 0) ? firstBeats : restBeats;
         for (int bt = 0; bt < nb; bt++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, randBeat(bt), 1'b1,
                          (ln == 0 && bt == 0), (bt == 0));
         end
         repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      end
      idle(3);
   endtask

   task automatic drainQueue();
      for (int i = 0; i < 20 && sb.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      checkOutput("queueDrain", 80'(sb.size()), 80'd0);
   endtask

   task automatic checkCounters(input logic [15:0] lb, input logic [15:0] fl, input logic [31:0] fc);
      checkOutput("lineBeats", 80'(line_beats), 80'(lb));
      checkOutput("frameLines", 80'(frame_lines), 80'(fl));
      checkOutput("frameCnt", 80'(frame_cnt), 80'(fc));
   endtask

   task automatic checkResetState();
      checkCounters(16'd0, 16'd0, 32'd0);
      checkOutput("rstFlags", 80'({pix_valid, pix_sof, pix_sol, err_lval, err_len}), 80'd0);
      checkOutput("rstData", pix_data, 80'd0);
      checkOutput("rstLed", 80'(GPIO_LED), 80'd0);
   endtask

   // Scoreboard side: every emitted beat must match the oldest prediction.
   always @(negedge clk) begin
      if (reset && pix_valid) begin
         if (sb.size() == 0) begin
            checkOutput("unexpectedValid", 80'd1, 80'd0);
         end else begin
            expBeat = sb.pop_front();
            checkOutput("beatCycle", 80'(cyc), 80'(expBeat.cyc));
            checkOutput("beatData", pix_data, expBeat.data);
            checkOutput("beatFlags", 80'({pix_sof, pix_sol}), 80'({expBeat.sof, expBeat.sol}));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, wanted finish");
      $fatal(1, "[TB] simulation timed out");
   end

   initial begin
      // Reset pulse
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkResetState();
      reset = 1'b1;
      idle(2);
      checkResetState();

      // 3 lines x 4 beats
      sendFrame(3, 4, 4);
      drainQueue();
      idle(2);
      checkCounters(16'd4, 16'd3, 32'd1);
      checkOutput("errAfterFrame1", 80'({err_lval, err_len}), 80'd0);
      checkOutput("dataHold", pix_data, lastData);
      checkOutput("ledFrame1", 80'(GPIO_LED), 80'h01);

      // Y lval lagging X by one clock
      idle(2);
      repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, randBeat(0), 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, randBeat(1), 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, randBeat(2), 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      idle(3);
      drainQueue();
      checkCounters(16'd3, 16'd1, 32'd2);
      checkOutput("errLvalSet", 80'(err_lval), 80'd1);
      errClr = 1'b1;
      idle(1);
      errClr = 1'b0;
      idle(2);
      checkOutput("errLvalClr", 80'(err_lval), 80'd0);

      // Zero-line frame; skew seen in the same clock as err_clr keeps the flag
      idle(2);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      errClr = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      errClr = 1'b0;
      idle(3);
      checkCounters(16'd3, 16'd0, 32'd3);
      checkOutput("errSetWins", 80'(err_lval), 80'd1);
      errClr = 1'b1;
      idle(1);
      errClr = 1'b0;
      idle(1);

      // Lines of 4 then 5 beats
      sendFrame(2, 4, 5);
      drainQueue();
      idle(2);
      checkCounters(16'd5, 16'd2, 32'd4);
      checkOutput("errLenSet", 80'({err_lval, err_len}), 80'd1);

      // lval toggling outside a frame
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'(i), 1'(i), 1'(i), randBeat(i), 1'b0, 1'b0, 1'b0);
      end
      idle(3);
      checkCounters(16'd5, 16'd2, 32'd4);
      checkOutput("ledErr", 80'(GPIO_LED), 80'h24);
      errClr = 1'b1;
      idle(1);
      errClr = 1'b0;
      idle(1);
      checkOutput("errLenClr", 80'(err_len), 80'd0);

      // Reset asserted mid-line, released mid-frame
      idle(2);
      repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, randBeat(0), 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, randBeat(1), 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, randBeat(2), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #2;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkResetState();
      #2;
      reset = 1'b1;
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, randBeat(3), 1'b0, 1'b0, 1'b0);
      repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, randBeat(4), 1'b0, 1'b0, 1'b0);
      repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      idle(3);
      checkCounters(16'd0, 16'd0, 32'd0);
      sendFrame(2, 3, 3);
      drainQueue();
      idle(2);
      checkCounters(16'd3, 16'd2, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/cl.md
CL -- requirements
Module: cl

Interface
REQ-001 SHALL expose: cl_x_pclk  in  1  sole clock; Camera Link X pixel clock; all logic on its rising edge.
REQ-002 SHALL expose: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL expose: cl_fval  in  1  frame valid.
REQ-004 SHALL expose: cl_x_lval, cl_y_lval, cl_z_lval  in  1 each  line valid per chip; Y and Z sampled on cl_x_pclk.
REQ-005 SHALL expose: cl_port_a .. cl_port_j  in  8 each  pixel bytes (Full configuration, 80 bits/clock).
REQ-006 SHALL expose: err_clr  in  1  synchronous clear of sticky error flags.
REQ-007 SHALL expose: pix_data  out  80  {j,i,h,g,f,e,d,c,b,a}, port a in bits 7:0.
REQ-008 SHALL expose: pix_valid, pix_sof, pix_sol  out  1 each  beat valid, first beat of frame, first beat of line.
REQ-009 SHALL expose: line_beats  out  16  beat count of last completed line.
REQ-010 SHALL expose: frame_lines  out  16  line count of last completed frame.
REQ-011 SHALL expose: frame_cnt  out  32  completed frames since reset.
REQ-012 SHALL expose: err_lval, err_len  out  1 each  sticky error flags.
REQ-013 SHALL expose: GPIO_LED  out  8  status: {fval_s, lval_s, err_lval|err_len, frame_cnt[4:0]}.

Function
REQ-014 SHALL register all Camera Link inputs once (stage s0) before any use; fval_s/lval_s denote s0 copies of cl_fval/cl_x_lval.
REQ-015 SHALL qualify a beat as active when fval_s=1 and lval_s=1; Y/Z lval never qualify data.
REQ-016 SHALL drive pix_data/pix_valid one clock after s0, i.e. 2 cycles from input pins to outputs; pix_data holds last value when pix_valid=0.
REQ-017 SHALL assert pix_sol with the first active beat after lval_s rose (or after fval_s rose with lval_s already high).
REQ-018 SHALL assert pix_sof with the first active beat of a frame; pix_sof implies pix_sol.
REQ-019 SHALL count active beats per line in 16-bit counter, saturating at 0xFFFF.
REQ-020 SHALL, at line end (active beat followed by inactive), load line_beats with the beat count and increment a 16-bit per-frame line counter (saturating).
REQ-021 SHALL, on fval_s falling edge, load frame_lines with line counter, increment frame_cnt (wraps at 2^32), clear line counter.
REQ-022 SHALL treat lval_s without fval_s as inactive; a line cut by fval falling still counts as a completed line (line end and frame end same cycle: line first, then frame).
REQ-023 SHALL set err_lval when fval_s=1 and Y or Z lval differs from X lval in s0.
REQ-024 SHALL set err_len when a completed line within one frame has beat count different from the first line of that frame.
REQ-025 SHALL clear both error flags when err_clr=1; a simultaneous set condition wins (flag remains 1).
REQ-026 SHALL ignore fval_s pulses with zero lines for frame_lines? No: such a frame SHALL still increment frame_cnt and load frame_lines=0.

Reset
REQ-027 SHALL, while reset=0, asynchronously force all outputs, counters, flags and s0 registers to 0.
REQ-028 SHALL, on reset release mid-frame, ignore the partial frame until fval_s next rises (no pix_sof, no frame_cnt increment for it).

Verification
REQ-029 Reset pulse (1 to 0 to 1) -> all outputs 0, GPIO_LED=0x00.
REQ-030 Frame of 3 lines x 4 beats, port a=beat index -> pix_valid 12 beats, pix_sof once, pix_sol 3 times, line_beats=4, frame_lines=3, frame_cnt=1, data at 2-cycle latency.
REQ-031 Y lval lagging X by one clock inside fval -> err_lval=1; err_clr pulse -> 0.
REQ-032 Lines of 4 then 5 beats in one frame -> err_len=1, line_beats=5.
REQ-033 lval toggling with fval=0 -> no pix_valid, counters unchanged.
REQ-034 Reset asserted mid-line, released mid-frame -> no output until next fval rise; next full frame gives frame_cnt=1.
